// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write arbiter.
// A word moves on a cycle where req_valid[i] & req_ready[i]; valid may drop at any time and releases the grant.
interface async_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          grant_valid;
  logic [GID_W-1:0]              grant_id;
  logic [CNT_WIDTH-1:0]          wr_count;
  logic                          dbg_state;

  modport slave (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, grant_valid, grant_id, wr_count, dbg_state
  );

  modport master (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, grant_valid, grant_id, wr_count, dbg_state
  );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NUM_REQ requesters.
// dbg_state mirrors the FSM: 0 = IDLE (arbitrating), 1 = GRANT (forwarding one requester).
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  async_fifo_wr_arbiter_if.slave bus
);
  localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [GID_W-1:0]     grant_id_q, grant_id_d;
  logic [GID_W-1:0]     last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
  logic                 grant_valid_q, grant_valid_d;

  logic                  g_valid;
  logic [DATA_WIDTH-1:0] g_data;
  logic [GID_W-1:0]      pick;
  logic                  found;
  logic [GID_W-1:0]      cand;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic                  winc_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  // Granted requester's valid/data, selected by grant_id_q.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        g_valid = bus.req_valid[i];
        g_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= GID_W'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      wr_count_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      wr_count_q    <= wr_count_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    wr_count_d    = wr_count_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = GRANT;
          grant_id_d    = pick;
          last_grant_d  = pick;
          beat_cnt_d    = '0;
          grant_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (!g_valid) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          beat_cnt_d    = '0;
        end else if (winc_c) begin
          wr_count_d = wr_count_q + CNT_WIDTH'(1);
          if (beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            beat_cnt_d    = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
        // valid with wfull: stall, everything holds
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // Combinational outputs are gated by wrst_n so nothing leaks during the reset cycle.
  always_comb begin
    req_ready_c = '0;
    winc_c      = 1'b0;
    wdata_c     = '0;
    if (wrst_n && state_q == GRANT) begin
      winc_c = g_valid & ~bus.wfull;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == GID_W'(i)) req_ready_c[i] = ~bus.wfull;
      end
      if (winc_c) wdata_c = g_data;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.winc        = winc_c;
  assign bus.wdata       = wdata_c;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.wr_count    = wr_count_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Bench for async_fifo_wr_arbiter: scenario tasks plus a scoreboard of expected {grant_id, wdata} words.
module tb_async_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 16;
  localparam int GW = 2;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  logic wrst_w_n = 1'b0;
  always #5 wclk = ~wclk;

  async_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) m_if ();
  async_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .bus(m_if)
  );

  // Narrow-counter instance so the wrap can be reached in a few hundred cycles.
  async_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(8)) w_if ();
  async_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(8)) dut_w (
    .wclk(wclk), .wrst_n(wrst_w_n), .bus(w_if)
  );

  int vectors = 0;
  int errors  = 0;
  logic [GW+DW-1:0] exp_q[$];
  logic [GW+DW-1:0] mon_e;

  logic [7:0]    base[NR];
  int            sent_cnt[NR];
  int            limit[NR];
  logic [NR-1:0] active;
  logic [NR-1:0] acc;

  logic          s_winc, s_gv, s_state;
  logic [NR-1:0] s_ready;
  logic [GW-1:0] s_gid;
  logic [CW-1:0] s_cnt;
  logic [DW-1:0] s_wdata;

  function automatic logic [7:0] word(int i, int k);
    return base[i] + 8'(k);
  endfunction

  function automatic logic [GW+DW-1:0] ent(int i, int k);
    return {GW'(i), word(i, k)};
  endfunction

  task automatic apply_drive();
    for (int i = 0; i < NR; i++) begin
      m_if.req_data[i*DW +: DW] = word(i, sent_cnt[i]);
      m_if.req_valid[i]         = active[i] && (sent_cnt[i] < limit[i]);
    end
  endtask

  // Called at a negedge: samples the cycle, crosses the posedge, then advances the sources.
  task automatic tick();
    #3;
    s_winc  = m_if.winc;
    s_ready = m_if.req_ready;
    s_gv    = m_if.grant_valid;
    s_gid   = m_if.grant_id;
    s_cnt   = m_if.wr_count;
    s_state = m_if.dbg_state;
    s_wdata = m_if.wdata;
    acc     = m_if.req_valid & m_if.req_ready;
    @(posedge wclk);
    @(negedge wclk);
    for (int i = 0; i < NR; i++) if (acc[i]) sent_cnt[i]++;
    apply_drive();
  endtask

  task automatic reset_dut();
    wrst_n = 1'b0;
    active = '0;
    m_if.wfull = 1'b0;
    for (int i = 0; i < NR; i++) begin
      base[i]     = 8'($urandom_range(0, 255));
      sent_cnt[i] = 0;
      limit[i]    = 1000;
    end
    apply_drive();
    exp_q.delete();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // Scoreboard: every winc must match the oldest expected word.
  always begin
    @(negedge wclk);
    #3;
    if (m_if.winc === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got id=%0d data=%h, expected no write", m_if.grant_id, m_if.wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_if.grant_id, m_if.wdata} !== mon_e) begin
          errors++;
          $display("FAIL sb_word: got id=%0d data=%h, expected id=%0d data=%h",
                   m_if.grant_id, m_if.wdata, mon_e[GW+DW-1:DW], mon_e[DW-1:0]);
        end
      end
      vectors++;
      if (m_if.wfull !== 1'b0 || m_if.grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL inv_winc: wfull=%b grant_valid=%b, expected 0/1", m_if.wfull, m_if.grant_valid);
      end
    end
  end

  task automatic test_reset();
    wrst_n = 1'b0;
    active = '1;
    apply_drive();
    for (int t = 1; t <= 3; t++) begin
      tick();
      vectors++;
      if ({s_winc, s_ready, s_gv, s_gid} !== '0 || s_cnt !== '0) begin
        errors++;
        $display("FAIL reset t=%0d: winc=%b ready=%b gv=%b gid=%0d cnt=%0d, expected all 0",
                 t, s_winc, s_ready, s_gv, s_gid, s_cnt);
      end
    end
  endtask

  task automatic test_round_robin();
    logic          exp_w;
    logic [GW-1:0] exp_g;
    logic [NR-1:0] exp_r;
    reset_dut();
    active = '1;
    apply_drive();
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 4; k++) exp_q.push_back(ent(r % 4, (r / 4) * 4 + k));
    for (int t = 1; t <= 25; t++) begin
      exp_w = (t % 5) != 1;
      exp_g = GW'(((t - 1) / 5) % 4);
      exp_r = exp_w ? (NR'(1) << exp_g) : '0;
      tick();
      vectors++;
      if (s_winc !== exp_w || s_gv !== exp_w || s_ready !== exp_r) begin
        errors++;
        $display("FAIL rr t=%0d: winc=%b gv=%b ready=%b, expected %b/%b/%b",
                 t, s_winc, s_gv, s_ready, exp_w, exp_w, exp_r);
      end
      if (exp_w) begin
        vectors++;
        if (s_gid !== exp_g) begin
          errors++;
          $display("FAIL rr_gid t=%0d: got %0d, expected %0d", t, s_gid, exp_g);
        end
      end
      if (t == 21) begin
        vectors++;
        if (s_cnt !== CW'(16)) begin
          errors++;
          $display("FAIL rr_count: got %0d, expected 16", s_cnt);
        end
      end
    end
    active = '0;
    apply_drive();
    tick();
    vectors++;
    if (exp_q.size() != 0 || s_cnt !== CW'(20)) begin
      errors++;
      $display("FAIL rr_end: pending=%0d cnt=%0d, expected 0/20", exp_q.size(), s_cnt);
    end
  endtask

  task automatic test_early_release();
    logic [10:1] exp_w;
    exp_w = 10'b0100100110;
    reset_dut();
    limit[2] = 2;
    limit[3] = 1;
    limit[0] = 1;
    active = 4'b0100;
    apply_drive();
    exp_q.push_back(ent(2, 0));
    exp_q.push_back(ent(2, 1));
    exp_q.push_back(ent(3, 0));
    exp_q.push_back(ent(0, 0));
    for (int t = 1; t <= 10; t++) begin
      if (t == 4) begin
        active = 4'b1101;
        apply_drive();
      end
      tick();
      vectors++;
      if (s_winc !== exp_w[t]) begin
        errors++;
        $display("FAIL early_winc t=%0d: got %b, expected %b", t, s_winc, exp_w[t]);
      end
      if (t == 5) begin
        vectors++;
        if (s_state !== 1'b0 || s_gv !== 1'b0) begin
          errors++;
          $display("FAIL early_idle: state=%b gv=%b, expected 0/0", s_state, s_gv);
        end
      end
      if (t == 6 || t == 9) begin
        vectors++;
        if (s_gid !== ((t == 6) ? GW'(3) : GW'(0))) begin
          errors++;
          $display("FAIL early_gid t=%0d: got %0d, expected %0d", t, s_gid, (t == 6) ? 3 : 0);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0 || s_cnt !== CW'(4)) begin
      errors++;
      $display("FAIL early_end: pending=%0d cnt=%0d, expected 0/4", exp_q.size(), s_cnt);
    end
  endtask

  task automatic test_full_stall();
    logic [11:1] exp_w;
    exp_w = 11'b01100000110;
    reset_dut();
    limit[1] = 4;
    active = 4'b0010;
    apply_drive();
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(1, k));
    for (int t = 1; t <= 11; t++) begin
      m_if.wfull = (t >= 4 && t <= 8);
      tick();
      vectors++;
      if (s_winc !== exp_w[t]) begin
        errors++;
        $display("FAIL stall_winc t=%0d: got %b, expected %b", t, s_winc, exp_w[t]);
      end
      if (t >= 4 && t <= 8) begin
        vectors++;
        if (s_ready !== '0 || s_gid !== GW'(1) || s_state !== 1'b1 || s_gv !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold t=%0d: ready=%b gid=%0d state=%b gv=%b, expected 0/1/1/1",
                   t, s_ready, s_gid, s_state, s_gv);
        end
      end
      if (t == 6) begin
        vectors++;
        if (s_cnt !== CW'(2)) begin
          errors++;
          $display("FAIL stall_cnt: got %0d, expected 2", s_cnt);
        end
      end
    end
    m_if.wfull = 1'b0;
    vectors++;
    if (exp_q.size() != 0 || s_cnt !== CW'(4) || s_state !== 1'b0) begin
      errors++;
      $display("FAIL stall_end: pending=%0d cnt=%0d state=%b, expected 0/4/0", exp_q.size(), s_cnt, s_state);
    end
  endtask

  task automatic test_last_beat();
    logic [9:1] exp_w;
    exp_w = 9'b010101110;
    reset_dut();
    active = 4'b0001;
    apply_drive();
    for (int k = 0; k < 5; k++) exp_q.push_back(ent(0, k));
    for (int t = 1; t <= 9; t++) begin
      m_if.wfull = (t == 5);
      if (t == 9) begin
        active = '0;
        apply_drive();
      end
      tick();
      vectors++;
      if (s_winc !== exp_w[t]) begin
        errors++;
        $display("FAIL last_winc t=%0d: got %b, expected %b", t, s_winc, exp_w[t]);
      end
      if (t == 5) begin
        vectors++;
        if (s_state !== 1'b1 || s_cnt !== CW'(3)) begin
          errors++;
          $display("FAIL last_hold: state=%b cnt=%0d, expected 1/3", s_state, s_cnt);
        end
      end
      if (t == 7) begin
        vectors++;
        if (s_state !== 1'b0 || s_gv !== 1'b0) begin
          errors++;
          $display("FAIL last_idle: state=%b gv=%b, expected 0/0", s_state, s_gv);
        end
      end
    end
    m_if.wfull = 1'b0;
    vectors++;
    if (exp_q.size() != 0 || s_cnt !== CW'(5)) begin
      errors++;
      $display("FAIL last_end: pending=%0d cnt=%0d, expected 0/5", exp_q.size(), s_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:1] exp_w;
    exp_w = 7'b0100110;
    reset_dut();
    active = 4'b0100;
    apply_drive();
    exp_q.push_back(ent(2, 0));
    exp_q.push_back(ent(2, 1));
    exp_q.push_back(ent(0, 0));
    for (int t = 1; t <= 7; t++) begin
      if (t == 4) begin
        wrst_n = 1'b0;
        active = '1;
        apply_drive();
      end
      if (t == 5) wrst_n = 1'b1;
      if (t == 7) begin
        active = '0;
        apply_drive();
      end
      tick();
      vectors++;
      if (s_winc !== exp_w[t]) begin
        errors++;
        $display("FAIL rstmid_winc t=%0d: got %b, expected %b", t, s_winc, exp_w[t]);
      end
      if (t == 4) begin
        vectors++;
        if (s_ready !== '0 || s_wdata !== '0) begin
          errors++;
          $display("FAIL rstmid_gate: ready=%b wdata=%h, expected 0/00", s_ready, s_wdata);
        end
      end
      if (t == 5) begin
        vectors++;
        if (s_state !== 1'b0 || s_gv !== 1'b0 || s_cnt !== '0) begin
          errors++;
          $display("FAIL rstmid_clear: state=%b gv=%b cnt=%0d, expected 0/0/0", s_state, s_gv, s_cnt);
        end
      end
      if (t == 6) begin
        vectors++;
        if (s_gid !== GW'(0)) begin
          errors++;
          $display("FAIL rstmid_gid: got %0d, expected 0", s_gid);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_end: pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int   model;
    int   budget;
    logic seen;
    model = 0;
    budget = 0;
    w_if.req_valid = '1;
    @(negedge wclk);
    wrst_w_n = 1'b1;
    while (model < 255 && budget < 2000) begin
      #3;
      if (w_if.winc === 1'b1) model++;
      @(negedge wclk);
      budget++;
    end
    w_if.req_valid = '0;
    vectors++;
    if (model != 255) begin
      errors++;
      $display("FAIL wrap_timeout: saw %0d writes, expected 255", model);
    end
    #3;
    vectors++;
    if (w_if.wr_count !== 8'd255 || w_if.winc !== 1'b0) begin
      errors++;
      $display("FAIL wrap_preload: cnt=%0d winc=%b, expected 255/0", w_if.wr_count, w_if.winc);
    end
    @(negedge wclk);
    @(negedge wclk);
    w_if.req_valid = 4'b0001;
    seen = 1'b0;
    budget = 0;
    while (!seen && budget < 20) begin
      #3;
      if (w_if.winc === 1'b1) seen = 1'b1;
      @(negedge wclk);
      budget++;
    end
    w_if.req_valid = '0;
    #3;
    vectors++;
    if (!seen || w_if.wr_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero: seen=%b cnt=%0d, expected 1/0", seen, w_if.wr_count);
    end
  endtask

  initial begin
    active = '0;
    for (int i = 0; i < NR; i++) begin
      base[i]     = 8'h00;
      sent_cnt[i] = 0;
      limit[i]    = 1000;
    end
    m_if.wfull     = 1'b0;
    m_if.req_valid = '0;
    m_if.req_data  = '0;
    w_if.wfull     = 1'b0;
    w_if.req_valid = '0;
    w_if.req_data  = '0;
    @(negedge wclk);
    reset_dut();
    test_reset();
    test_round_robin();
    test_early_release();
    test_full_stall();
    test_last_beat();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
